// File: rtl/dtpu_infifo_axis_bridge.sv
// AXI4-Stream slave to first-word-fall-through FIFO feeding the dtpu_core input port.
// Optional macro DTPU_INFIFO_TLAST_EN stores tlast per word and exposes it on rd_last.
module dtpu_infifo_axis_bridge #(
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty_n,
    output logic                  rd_last,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  underflow
);

`ifdef DTPU_INFIFO_TLAST_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

    logic [MEM_W-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop;
    logic [MEM_W-1:0]      wr_word, head_word;

    // Full/empty come from the occupancy count, so pointers may freely alias.
    assign empty_n       = (level_q != '0);
    assign s_axis_tready = ~areset & (level_q != FULL_LVL);
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = rd_en & empty_n;

`ifdef DTPU_INFIFO_TLAST_EN
    assign wr_word = {s_axis_tlast, s_axis_tdata};
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign wr_word      = s_axis_tdata;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q | (rd_en & ~empty_n);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; push is already gated by areset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    assign head_word = mem_q[rd_ptr_q];
    assign rd_data   = empty_n ? head_word[DATA_WIDTH-1:0] : '0;
    assign level     = level_q;
    assign underflow = underflow_q;

`ifdef DTPU_INFIFO_TLAST_EN
    assign rd_last = empty_n & head_word[DATA_WIDTH];
`else
    assign rd_last = 1'b0;
`endif

endmodule

// File: tb/tb_dtpu_infifo_axis_bridge.sv
// Randomized and directed bench for dtpu_infifo_axis_bridge against a queue model.
// Honours DTPU_INFIFO_TLAST_EN when it is defined for the build.
module tb_dtpu_infifo_axis_bridge;
    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] rd_data;
    logic          rd_en, empty_n, rd_last, underflow;
    logic [4:0]    level;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: FIFO contents as a queue, bit 64 holds tlast.
    logic [DW:0] mq[$];
    logic        m_uf;

    always #5 clk = ~clk;

    dtpu_infifo_axis_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .rd_data(rd_data), .rd_en(rd_en), .empty_n(empty_n),
        .rd_last(rd_last), .level(level), .underflow(underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic vld, input logic [63:0] d, input logic last,
                        input logic rde, input logic rst);
        logic exp_rdy, do_push, do_pop;
        logic [DW:0] head;
        areset = rst; s_axis_tvalid = vld; s_axis_tdata = d; s_axis_tlast = last; rd_en = rde;
        @(negedge clk);
        exp_rdy = !rst && (mq.size() < DEPTH);
        head    = (mq.size() != 0) ? mq[0] : '0;
        check("tready",    64'(s_axis_tready), 64'(exp_rdy));
        check("empty_n",   64'(empty_n),       64'(mq.size() != 0));
        check("rd_data",   rd_data,            head[DW-1:0]);
        check("level",     64'(level),         64'(mq.size()));
        check("underflow", 64'(underflow),     64'(m_uf));
`ifdef DTPU_INFIFO_TLAST_EN
        check("rd_last",   64'(rd_last),       64'(head[DW]));
`else
        check("rd_last",   64'(rd_last),       64'd0);
`endif
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_uf = 1'b0;
        end else begin
            do_push = vld && exp_rdy;
            do_pop  = rde && (mq.size() != 0);
            if (rde && mq.size() == 0) m_uf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({last, d});
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_uf = 1'b0;
        areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);

        // 1: single word through
        step(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        check("t1_level1", 64'(level), 64'd1);
        check("t1_data",   rd_data,    64'h1);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // 2: fill to full, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0);
        check("t2_full_level", 64'(level), 64'd16);
        check("t2_full_rdy",   64'(s_axis_tready), 64'd0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
        // 3: at full, push+pop together: no push this cycle, push next cycle
        step(1'b1, 64'hBEEF, 1'b0, 1'b1, 1'b0);
        check("t3_level15", 64'(level), 64'd15);
        step(1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b0);
        check("t3_level16", 64'(level), 64'd16);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        // 4: steady state at level 5 across pointer wrap
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 64'h300 + 64'(i), 1'b0, 1'b1, 1'b0);
        check("t4_level5", 64'(level), 64'd5);

        // 5: underflow is sticky until reset
        for (int i = 0; i < 6; i++) step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        check("t5_uf", 64'(underflow), 64'd1);
        step(1'b1, 64'h55, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // 6: reset mid-stream discards contents
        for (int i = 0; i < 3; i++) step(1'b1, 64'h400 + 64'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h4FF, 1'b0, 1'b0, 1'b1);
        check("t6_level0", 64'(level), 64'd0);
        check("t6_uf_clr", 64'(underflow), 64'd0);
        step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        // Random phase with varying push/pop pressure and rare resets
        for (int blk = 0; blk < 8; blk++) begin
            int pv, pr;
            pv = $urandom_range(20, 95);
            pr = $urandom_range(20, 95);
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(99) < pv), {$urandom, $urandom}, $urandom_range(1),
                     ($urandom_range(99) < pr), ($urandom_range(299) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
